cvxif_copro_responder: RTL and testbench

- Coprocessor-side responder for the CV-X-IF interface enabled by CvxifEn. The CVA6 core is the initiator.
- The block decodes custom-0 instructions offered on the issue channel and accepts or rejects each one.
- Accepted instructions are buffered in order. A commit channel marks each one committed or killed.
- Committed instructions return through the result channel with valid/ready backpressure.
- Sits beside the core, in place of the example coprocessor, for cv32a65x-class (XLEN=32) builds.

---
 rtl/cvxif_copro_responder.sv | 173 +++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-0 ops, buffers them in
// issue order, and returns committed results with valid/ready backpressure.
module cvxif_copro_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned NrEntries = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int unsigned PW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
  localparam int unsigned CW = $clog2(NrEntries + 1);
  localparam logic [CW-1:0] Depth = CW'(NrEntries);

  logic [NrEntries-1:0] vld_q, vld_d;
  logic [NrEntries-1:0] cmt_q, cmt_d;
  logic [NrEntries-1:0] kil_q, kil_d;
  logic [NrEntries-1:0] we_q, we_d;
  logic [IdWidth-1:0]   id_q  [NrEntries];
  logic [IdWidth-1:0]   id_d  [NrEntries];
  logic [4:0]           rd_q  [NrEntries];
  logic [4:0]           rd_d  [NrEntries];
  logic [XLEN-1:0]      dat_q [NrEntries];
  logic [XLEN-1:0]      dat_d [NrEntries];
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic            dec_acc;
  logic            dec_we;
  logic [XLEN-1:0] dec_data;
  logic            push;
  logic            pop;
  logic            hit;
  logic            head_done;
  logic            res_vld;
  logic            unused_instr;

  assign unused_instr = ^issue_instr_i[31:15];

  always_comb begin
    dec_acc  = 1'b0;
    dec_we   = 1'b0;
    dec_data = '0;
    if (issue_instr_i[6:0] == 7'b0001011) begin
      unique case (issue_instr_i[14:12])
        3'b000: begin
          dec_acc  = 1'b1;
          dec_we   = 1'b1;
          dec_data = issue_rs1_i + issue_rs2_i;
        end
        3'b001: begin
          dec_acc  = 1'b1;
          dec_we   = 1'b1;
          dec_data = issue_rs1_i - issue_rs2_i;
        end
        3'b010: begin
          dec_acc  = 1'b1;
          dec_we   = 1'b1;
          dec_data = issue_rs1_i ^ issue_rs2_i;
        end
        3'b011: dec_acc = 1'b1;
        default: dec_acc = 1'b0;
      endcase
    end
  end

  // Ready looks at the registered count only: no pop-to-push bypass.
  assign issue_ready_o     = !rst_i && (cnt_q < Depth);
  assign issue_accept_o    = !rst_i && issue_valid_i && dec_acc;
  assign issue_writeback_o = !rst_i && issue_valid_i && dec_we;

  assign push = issue_valid_i && issue_ready_o && dec_acc;
  assign hit  = commit_valid_i && (commit_id_i == issue_id_i);

  assign head_done = vld_q[rptr_q] && cmt_q[rptr_q];
  assign res_vld   = !rst_i && head_done && !kil_q[rptr_q];
  assign pop       = !rst_i && head_done
                   && (kil_q[rptr_q] || result_ready_i);

  assign result_valid_o = res_vld;
  assign result_id_o    = res_vld ? id_q[rptr_q]  : '0;
  assign result_data_o  = res_vld ? dat_q[rptr_q] : '0;
  assign result_rd_o    = res_vld ? rd_q[rptr_q]  : '0;
  assign result_we_o    = res_vld && we_q[rptr_q];

  always_comb begin
    vld_d  = vld_q;
    cmt_d  = cmt_q;
    kil_d  = kil_q;
    we_d   = we_q;
    id_d   = id_q;
    rd_d   = rd_q;
    dat_d  = dat_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (commit_valid_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        if (vld_q[i] && id_q[i] == commit_id_i) begin
          cmt_d[i] = 1'b1;
          kil_d[i] = commit_kill_i;
        end
      end
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      cmt_d[wptr_q] = hit;
      kil_d[wptr_q] = hit && commit_kill_i;
      we_d[wptr_q]  = dec_we;
      id_d[wptr_q]  = issue_id_i;
      rd_d[wptr_q]  = issue_instr_i[11:7];
      dat_d[wptr_q] = dec_data;
      wptr_d        = wptr_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      cmt_q  <= '0;
      kil_q  <= '0;
      we_q   <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NrEntries; i++) begin
        id_q[i]  <= '0;
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      cmt_q  <= cmt_d;
      kil_q  <= kil_d;
      we_q   <= we_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      id_q   <= id_d;
      rd_q   <= rd_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: directed plan steps, then random
// traffic, all outputs checked every cycle against a queue model.
module tb_cvxif_copro_responder;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        accept;
  logic        wb;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_id;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        c;
    logic        k;
  } ent_t;

  ent_t q[$];

  localparam logic [31:0] ADD = 32'h0000050B;
  localparam logic [31:0] SUB = 32'h0000150B;
  localparam logic [31:0] XOR = 32'h0000250B;
  localparam logic [31:0] NOP = 32'h0000350B;

  cvxif_copro_responder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs1_i       (rs1),
    .issue_rs2_i       (rs2),
    .issue_accept_o    (accept),
    .issue_writeback_o (wb),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (res_valid),
    .result_ready_i    (res_ready),
    .result_id_o       (res_id),
    .result_data_o     (res_data),
    .result_rd_o       (res_rd),
    .result_we_o       (res_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void spec_op(input logic [31:0] ins,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic acc, output logic we,
                                  output logic [31:0] d);
    acc = 1'b0;
    we  = 1'b0;
    d   = 32'd0;
    if (ins[6:0] == 7'h0B) begin
      case (ins[14:12])
        3'd0: begin acc = 1; we = 1; d = a + b; end
        3'd1: begin acc = 1; we = 1; d = a - b; end
        3'd2: begin acc = 1; we = 1; d = a ^ b; end
        3'd3: acc = 1;
        default: ;
      endcase
    end
  endfunction

  task automatic check_all();
    logic a, w, rv;
    logic [31:0] d;
    spec_op(issue_instr, rs1, rs2, a, w, d);
    rv = !rst && q.size() > 0 && q[0].c && !q[0].k;
    chk("ready", 32'(issue_ready), 32'(!rst && q.size() < 4));
    chk("accept", 32'(accept), 32'(!rst && issue_valid && a));
    chk("writeback", 32'(wb), 32'(!rst && issue_valid && w));
    chk("res_valid", 32'(res_valid), 32'(rv));
    if (rv) begin
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_data", res_data, q[0].data);
      chk("res_rd", 32'(res_rd), 32'(q[0].rd));
      chk("res_we", 32'(res_we), 32'(q[0].we));
    end
    if (rst) begin
      chk("rst_outs", {res_data[15:0], 7'd0, res_rd, res_id},
          32'd0);
      chk("rst_we", 32'(res_we), 32'd0);
    end
  endtask

  task automatic update_model();
    logic a, w, hs, pop;
    logic [31:0] d;
    ent_t e;
    if (rst) begin
      q.delete();
      return;
    end
    spec_op(issue_instr, rs1, rs2, a, w, d);
    hs  = issue_valid && q.size() < 4;
    pop = q.size() > 0 && q[0].c && (q[0].k || res_ready);
    if (commit_valid) begin
      foreach (q[i]) begin
        if (q[i].id == commit_id) begin
          q[i].c = 1'b1;
          q[i].k = commit_kill;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (hs && a) begin
      e.id   = issue_id;
      e.rd   = issue_instr[11:7];
      e.we   = w;
      e.data = d;
      e.c    = commit_valid && commit_id == issue_id;
      e.k    = e.c && commit_kill;
      q.push_back(e);
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_instr  = 32'd0;
    issue_id     = 4'd0;
    rs1          = 32'd0;
    rs2          = 32'd0;
    commit_valid = 1'b0;
    commit_id    = 4'd0;
    commit_kill  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    issue_instr = ins;
    issue_id    = id;
    rs1         = a;
    rs2         = b;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  initial begin
    logic [31:0] hold_d;
    logic [3:0]  hold_id;
    logic [4:0]  hold_rd;
    logic        hold_we;
    idle();
    rst       = 1'b1;
    res_ready = 1'b0;

    // reset held 3 cycles, with live traffic on the inputs
    issue(ADD, 4'd1, 32'd1, 32'd2);
    commit(4'd1, 1'b0);
    step();
    idle();
    step();
    step();
    chk("rst_ready", 32'(issue_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(issue_ready), 32'd1);
    chk("post_rst_rv", 32'(res_valid), 32'd0);

    // ADD issued and committed in the same cycle
    issue(ADD, 4'd3, 32'd5, 32'd7);
    commit(4'd3, 1'b0);
    #1;
    chk("add_accept", 32'(accept), 32'd1);
    chk("add_wb", 32'(wb), 32'd1);
    step();
    idle();
    chk("add_rv", 32'(res_valid), 32'd1);
    chk("add_id", 32'(res_id), 32'd3);
    chk("add_data", res_data, 32'd12);
    chk("add_rd", 32'(res_rd), 32'd10);
    chk("add_we", 32'(res_we), 32'd1);
    res_ready = 1'b1;
    step();

    // SUB wraps, then is held under backpressure
    issue(SUB, 4'd5, 32'd3, 32'd5);
    commit(4'd5, 1'b0);
    res_ready = 1'b0;
    step();
    idle();
    chk("sub_data", res_data, 32'hFFFFFFFE);
    hold_d  = res_data;
    hold_id = res_id;
    hold_rd = res_rd;
    hold_we = res_we;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rv", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, hold_d);
      chk("hold_meta", {22'd0, res_we, res_rd, res_id},
          {22'd0, hold_we, hold_rd, hold_id});
    end
    res_ready = 1'b1;
    step();
    chk("sub_popped", 32'(res_valid), 32'd0);

    // rejected opcode, then NOP
    issue(32'h00000033, 4'd6, 32'd1, 32'd1);
    #1;
    chk("rej_accept", 32'(accept), 32'd0);
    chk("rej_wb", 32'(wb), 32'd0);
    step();
    idle();
    step();
    chk("rej_nores", 32'(res_valid), 32'd0);
    issue(NOP, 4'd7, 32'd9, 32'd9);
    commit(4'd7, 1'b0);
    #1;
    chk("nop_accept", 32'(accept), 32'd1);
    chk("nop_wb", 32'(wb), 32'd0);
    step();
    idle();
    chk("nop_rv", 32'(res_valid), 32'd1);
    chk("nop_we", 32'(res_we), 32'd0);
    chk("nop_data", res_data, 32'd0);
    step();

    // fill the buffer, kill the oldest, commit the rest
    for (int i = 0; i < 4; i++) begin
      issue(XOR, 4'(i), 32'(i), 32'hF0);
      step();
    end
    idle();
    chk("full_ready", 32'(issue_ready), 32'd0);
    commit(4'd0, 1'b1);
    step();
    chk("kill_rv", 32'(res_valid), 32'd0);
    chk("kill_ready", 32'(issue_ready), 32'd0);
    commit(4'd1, 1'b0);
    step();
    chk("pop_ready", 32'(issue_ready), 32'd1);
    chk("ord_id1", 32'(res_id), 32'd1);
    commit(4'd2, 1'b0);
    step();
    chk("ord_id2", 32'(res_id), 32'd2);
    commit(4'd3, 1'b0);
    step();
    chk("ord_id3", 32'(res_id), 32'd3);
    idle();
    step();

    // out-of-order commit still yields in-order results
    issue(ADD, 4'd1, 32'd1, 32'd1);
    step();
    issue(ADD, 4'd2, 32'd2, 32'd2);
    step();
    idle();
    commit(4'd2, 1'b0);
    step();
    idle();
    chk("ooo_block", 32'(res_valid), 32'd0);
    step();
    commit(4'd1, 1'b0);
    step();
    idle();
    chk("ooo_first", 32'(res_id), 32'd1);
    step();
    chk("ooo_second", 32'(res_id), 32'd2);
    step();

    // reset with two entries in flight
    issue(ADD, 4'd4, 32'd4, 32'd4);
    step();
    issue(ADD, 4'd5, 32'd5, 32'd5);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    commit(4'd4, 1'b0);
    step();
    commit(4'd5, 1'b0);
    step();
    idle();
    step();
    chk("midrst_rv", 32'(res_valid), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 5) != 0) ins[6:0] = 7'h0B;
        issue(ins, 4'($urandom), $urandom, $urandom);
      end
      if ($urandom_range(0, 1) != 0) begin
        if (q.size() > 0 && $urandom_range(0, 9) < 7)
          commit(q[$urandom_range(0, q.size() - 1)].id,
                 ($urandom_range(0, 3) == 0));
        else
          commit(4'($urandom), 1'($urandom));
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
